// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter step used by every counter table.
package bpred_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    function automatic ctr_t sat2_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_ctr_table.sv
// Array of 2-bit saturating direction counters: one async read port for IF,
// one read-modify-write port for EX resolution, synchronous reset to WNT.
module bpred_ctr_table
    import bpred_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    ctr_t mem [ENTRIES];

    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            mem[upd_idx] <= sat2_next(mem[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/bpred_bht.sv
// Branch predictor for the 5-stage pipeline: tagged direct-mapped BTB plus a
// 2-bit counter table (bimodal or gshare), trained non-speculatively from EX.
module bpred_bht
    import bpred_pkg::*;
#(
    parameter int PC_W   = 30,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 8,
    parameter int GSHARE = 0,
    parameter int GHR_W  = 6,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] btb_v;
    logic [TAG_W-1:0]   btb_tag [ENTRIES];
    logic [PC_W-1:0]    btb_tgt [ENTRIES];
    logic [GHR_W-1:0]   ghr;

    logic [IDX_W-1:0] if_bi, if_ci, upd_bi, upd_ci;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             if_hit;
    ctr_t             if_ctr;
    logic             upd_pc_unused;

    function automatic logic [IDX_W-1:0] ctr_index(input logic [IDX_W-1:0] bi,
                                                   input logic [GHR_W-1:0] hist);
        return (GSHARE != 0) ? (bi ^ IDX_W'(hist)) : bi;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val,
                                                  input logic inc);
        return (inc && (val != '1)) ? val + STAT_W'(1) : val;
    endfunction

    // Lookup path: combinational from registered state, no bypass of this cycle's update
    assign if_bi  = if_pc[IDX_W-1:0];
    assign if_tag = if_pc[IDX_W +: TAG_W];
    assign if_ci  = ctr_index(if_bi, ghr);
    assign if_hit = btb_v[if_bi] && (btb_tag[if_bi] == if_tag);

    assign pred_taken  = if_hit && if_ctr[1];
    assign pred_target = pred_taken ? btb_tgt[if_bi] : if_pc + PC_W'(1);

    assign upd_bi  = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[IDX_W +: TAG_W];
    assign upd_ci  = ctr_index(upd_bi, ghr);

    // Bits above the tag do not participate in indexing or tag compare
    assign upd_pc_unused = ^upd_pc[PC_W-1:IDX_W+TAG_W];

    bpred_ctr_table #(
        .IDX_W (IDX_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_ci),
        .rd_ctr    (if_ctr),
        .upd_en    (upd_valid),
        .upd_idx   (upd_ci),
        .upd_taken (upd_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_v         <= '0;
            ghr           <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                btb_v[upd_bi] <= 1'b1;
            end
            if (GSHARE != 0) begin
                ghr <= GHR_W'({ghr, upd_taken});
            end
            stat_branches <= sat_inc(stat_branches, 1'b1);
            stat_mispred  <= sat_inc(stat_mispred, upd_mispredict);
        end
    end

    // Tag/target need no reset: a cleared valid bit hides them. Hit-and-taken
    // rewrites the same tag, so one write covers both refresh and allocation.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[upd_bi] <= upd_tag;
            btb_tgt[upd_bi] <= upd_target;
        end
    end

endmodule
